// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel tone generator and detector.
//   COEF_FRAC     : fractional bits of the sincos coefficients, A(1,14)
//   DEF_*         : default widths (sample, log2 burst length, coefficient, guard bits)
//   tg_state_e    : tone generator FSM states
//   round_half_up : arithmetic right shift with round-half-up
//   saturate      : clamp a signed value to a w-bit signed range
package goertzel_pkg;

  localparam int unsigned COEF_FRAC = 14;

  localparam int unsigned DEF_SW  = 12;
  localparam int unsigned DEF_LGN = 8;
  localparam int unsigned DEF_CW  = 16;
  localparam int unsigned DEF_GB  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWaitCoef,
    StRun
  } tg_state_e;

  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] x,
                                                       input int unsigned      sh);
    logic signed [63:0] bias;
    if (sh == 0) begin
      return x;
    end
    bias = 64'sd1 <<< (sh - 1);
    return (x + bias) >>> sh;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned      w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (x > max_v) begin
      return max_v;
    end
    if (x < min_v) begin
      return min_v;
    end
    return x;
  endfunction

endpackage

// File: rtl/goertzel_sat.sv
// Signed saturating narrower: out_o = clamp(in_i >>> SHIFT) to OUT_W signed bits.
//   in_i  : signed input, IN_W bits
//   out_o : signed output, OUT_W bits (IN_W must exceed OUT_W)
module goertzel_sat #(
  parameter int unsigned IN_W  = 34,
  parameter int unsigned OUT_W = 17,
  parameter int unsigned SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o
);

  logic signed [IN_W-1:0]  shifted;
  logic        [IN_W-OUT_W:0] hi;

  always_comb begin
    shifted = in_i >>> SHIFT;
    // In range iff every bit above the output sign bit matches it.
    hi = shifted[IN_W-1:OUT_W-1];
    if ((&hi) || !(|hi)) begin
      out_o = shifted[OUT_W-1:0];
    end else if (hi[IN_W-OUT_W]) begin
      out_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      out_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/goertzel_tone_gen.sv
// Recursive sinusoid burst generator: emits N = 2^LGN samples of A*sin(2*pi*k*n/N)
// using y[n] = 2*cos*y[n-1] - y[n-2], seeded from the sincos coefficients.
// Optional build macro GOERTZEL_TG_REPEAT_EN: i_start on the o_last transfer re-seeds
// and starts the next burst with no gap.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_start, i_amp      : start a burst with amplitude A(0,11) (sampled in idle)
//   i_sin, i_cos        : coefficients A(1,14), taken when i_coef_valid in wait state
//   o_sample, o_valid   : sample stream, held while i_ready is low
//   i_ready, o_last     : downstream accept, last sample of burst marker
//   o_busy              : FSM not idle
module goertzel_tone_gen
  import goertzel_pkg::*;
#(
  parameter int unsigned SW  = DEF_SW,
  parameter int unsigned LGN = DEF_LGN,
  parameter int unsigned CW  = DEF_CW,
  parameter int unsigned GB  = DEF_GB
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic signed [SW-1:0] i_amp,
  input  logic signed [CW-1:0] i_sin,
  input  logic signed [CW-1:0] i_cos,
  input  logic                 i_coef_valid,
  output logic signed [SW-1:0] o_sample,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_busy
);

  localparam int unsigned IW = SW + GB + 1;
  localparam int unsigned PW = IW + CW;

  tg_state_e state_q, state_d;
  logic signed [SW-1:0]  amp_q, amp_d;
  logic signed [CW-1:0]  c_sin_q, c_sin_d, c_cos_q, c_cos_d, sin_sel;
  // y2 holds the sample being presented, y1 the one after it.
  logic signed [IW-1:0]  y1_q, y1_d, y2_q, y2_d, seed, y_new;
  logic        [LGN-1:0] count_q, count_d;
  logic                  valid_q, valid_d;
  logic signed [PW-1:0]  prod;
  logic signed [63:0]    upd_raw;
  logic                  xfer;

  always_comb begin
    // Seed uses the live coefficient on the latch cycle, the latched one on re-seed.
    sin_sel = (state_q == StWaitCoef) ? i_sin : c_sin_q;
    seed    = IW'(saturate(round_half_up(64'(amp_q) * 64'(sin_sel), COEF_FRAC - GB), IW));
    prod    = c_cos_q * y1_q;
    // (2*p + 2^13) >>> 14 == (p + 2^12) >>> 13, so the doubling never widens p.
    upd_raw = round_half_up(64'(prod), COEF_FRAC - 1) - 64'(y2_q);
  end

  goertzel_sat #(
    .IN_W (64),
    .OUT_W(IW),
    .SHIFT(0)
  ) u_sat_state (
    .in_i (upd_raw),
    .out_o(y_new)
  );

  goertzel_sat #(
    .IN_W (IW),
    .OUT_W(SW),
    .SHIFT(GB)
  ) u_sat_out (
    .in_i (y2_q),
    .out_o(o_sample)
  );

  assign xfer = valid_q & i_ready;

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    c_sin_d = c_sin_q;
    c_cos_d = c_cos_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    count_d = count_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          amp_d   = i_amp;
          state_d = StWaitCoef;
        end
      end
      StWaitCoef: begin
        if (i_coef_valid) begin
          c_sin_d = i_sin;
          c_cos_d = i_cos;
          y2_d    = '0;
          y1_d    = seed;
          count_d = '0;
          valid_d = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (xfer) begin
          if (&count_q) begin
`ifdef GOERTZEL_TG_REPEAT_EN
            if (i_start) begin
              y2_d    = '0;
              y1_d    = seed;
              count_d = '0;
            end else begin
              valid_d = 1'b0;
              state_d = StIdle;
            end
`else
            valid_d = 1'b0;
            state_d = StIdle;
`endif
          end else begin
            y2_d    = y1_q;
            y1_d    = y_new;
            count_d = count_q + LGN'(1);
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      amp_q   <= '0;
      c_sin_q <= '0;
      c_cos_q <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
      c_sin_q <= c_sin_d;
      c_cos_q <= c_cos_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_last  = valid_q & (&count_q);
  assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_goertzel_tone_gen.sv
module tb_goertzel_tone_gen;

  logic               i_clk;
  logic               i_rst;
  logic               i_start;
  logic signed [11:0] i_amp;
  logic signed [15:0] i_sin;
  logic signed [15:0] i_cos;
  logic               i_coef_valid;
  logic signed [11:0] o_sample;
  logic               o_valid;
  logic               i_ready;
  logic               o_last;
  logic               o_busy;

  int total = 0;
  int bad   = 0;

  int samp[0:511];
  int ref_s[0:255];
  int n_got, nlast, last_idx, unstable, gaps;

  goertzel_tone_gen dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_amp       (i_amp),
    .i_sin       (i_sin),
    .i_cos       (i_cos),
    .i_coef_valid(i_coef_valid),
    .o_sample    (o_sample),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_burst(input int amp, input int s, input int c);
    i_amp = 12'(amp);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_sin = 16'(s);
    i_cos = 16'(c);
    i_coef_valid = 1'b1;
    step();
    i_coef_valid = 1'b0;
    i_sin = 16'sd0;
    i_cos = 16'sd0;
  endtask

  // Collects transferred samples; i_start is driven high while n_got < start_until.
  task automatic capture(input int want, input bit rnd, input int start_until, input int budget);
    bit prev_stall;
    int prev_sample;
    bit prev_last;
    n_got = 0; nlast = 0; last_idx = -1; unstable = 0; gaps = 0;
    prev_stall = 1'b0; prev_sample = 0; prev_last = 1'b0;
    for (int cyc = 0; cyc < budget && n_got < want; cyc++) begin
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_start = (n_got < start_until);
      if (prev_stall && (!o_valid || int'(o_sample) != prev_sample || o_last != prev_last))
        unstable++;
      if (!o_valid && n_got > 0) gaps++;
      if (o_valid && i_ready) begin
        samp[n_got] = int'(o_sample);
        if (o_last) begin
          nlast++;
          last_idx = n_got;
        end
        n_got++;
      end
      prev_stall = o_valid && !i_ready;
      prev_sample = int'(o_sample);
      prev_last = o_last;
      step();
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", o_last); end
    total++; if (o_sample !== 12'sd0) begin bad++; $display("FAIL reset_sample: got %0d want 0", o_sample); end
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int peak;
    int sbad;
    real r;
    real err;
    i_amp = 12'sd1024;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", o_busy); end
    step();
    step();
    total++; if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      bad++; $display("FAIL wait_coef: got busy=%b valid=%b want busy=1 valid=0", o_busy, o_valid);
    end
    i_sin = 16'sd5139; i_cos = 16'sd15557; i_coef_valid = 1'b1;
    step();
    i_coef_valid = 1'b0;
    // Garbage on the coefficient inputs must not reach the running burst.
    i_sin = 16'sd9999; i_cos = -16'sd7777;
    total++; if (o_valid !== 1'b1 || o_sample !== 12'sd0) begin
      bad++; $display("FAIL first_valid: got valid=%b sample=%0d want valid=1 sample=0", o_valid, o_sample);
    end
    capture(256, 1'b0, 0, 1000);
    total++; if (n_got != 256) begin bad++; $display("FAIL basic_len: got %0d want 256", n_got); end
    total++; if (samp[1] < 320 || samp[1] > 322) begin bad++; $display("FAIL basic_s1: got %0d want 321+-1", samp[1]); end
    total++; if (samp[2] < 609 || samp[2] > 611) begin bad++; $display("FAIL basic_s2: got %0d want 610+-1", samp[2]); end
    peak = 0; sbad = 0;
    for (int n = 0; n < 256; n++) begin
      if (samp[n] > peak) peak = samp[n];
      if (-samp[n] > peak) peak = -samp[n];
      r = 1024.0 * $sin(2.0 * 3.14159265358979 * 13.0 * n / 256.0);
      err = real'(samp[n]) - r;
      if (err > 10.0 || err < -10.0) sbad++;
      ref_s[n] = samp[n];
    end
    total++; if (peak < 1020 || peak > 1028) begin bad++; $display("FAIL basic_peak: got %0d want 1020..1028", peak); end
    total++; if (sbad != 0) begin bad++; $display("FAIL basic_shape: got %0d samples off sine want 0", sbad); end
    total++; if (nlast != 1 || last_idx != 255) begin
      bad++; $display("FAIL basic_last: got count=%0d idx=%0d want count=1 idx=255", nlast, last_idx);
    end
    total++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL basic_end: got valid=%b busy=%b want 0 0", o_valid, o_busy);
    end
  endtask

  task automatic test_backpressure();
    int mism;
    start_burst(1024, 5139, 15557);
    capture(256, 1'b1, 0, 3000);
    mism = 0;
    for (int n = 0; n < 256; n++) if (samp[n] != ref_s[n]) mism++;
    total++; if (n_got != 256) begin bad++; $display("FAIL bp_len: got %0d want 256", n_got); end
    total++; if (mism != 0) begin bad++; $display("FAIL bp_samples: got %0d differing want 0", mism); end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d changes under stall want 0", unstable); end
    total++; if (nlast != 1 || last_idx != 255) begin
      bad++; $display("FAIL bp_last: got count=%0d idx=%0d want count=1 idx=255", nlast, last_idx);
    end
  endtask

  task automatic test_zero_tone();
    int nz;
    start_burst(1024, 0, 16384);
    capture(256, 1'b0, 0, 1000);
    nz = 0;
    for (int n = 0; n < 256; n++) if (samp[n] != 0) nz++;
    total++; if (n_got != 256 || nz != 0) begin
      bad++; $display("FAIL k0_burst: got len=%0d nonzero=%0d want len=256 nonzero=0", n_got, nz);
    end
    total++; if (last_idx != 255 || o_busy !== 1'b0) begin
      bad++; $display("FAIL k0_end: got last=%0d busy=%b want last=255 busy=0", last_idx, o_busy);
    end
  endtask

  task automatic test_saturation();
    int nbad;
    // Inconsistent coefficients make the recursion grow linearly until it clamps.
    start_burst(2047, 16383, 16384);
    capture(256, 1'b0, 0, 1000);
    nbad = 0;
    for (int n = 2; n < 256; n++) if (samp[n] != 2047) nbad++;
    total++; if (samp[0] != 0 || samp[1] != 2046) begin
      bad++; $display("FAIL sat_pos_head: got %0d,%0d want 0,2046", samp[0], samp[1]);
    end
    total++; if (n_got != 256 || nbad != 0) begin
      bad++; $display("FAIL sat_pos_clamp: got len=%0d off=%0d want len=256 off=0", n_got, nbad);
    end
    start_burst(-2047, 16383, 16384);
    capture(256, 1'b0, 0, 1000);
    nbad = 0;
    for (int n = 2; n < 256; n++) if (samp[n] != -2048) nbad++;
    total++; if (samp[0] != 0 || samp[1] != -2047) begin
      bad++; $display("FAIL sat_neg_head: got %0d,%0d want 0,-2047", samp[0], samp[1]);
    end
    total++; if (n_got != 256 || nbad != 0) begin
      bad++; $display("FAIL sat_neg_clamp: got len=%0d off=%0d want len=256 off=0", n_got, nbad);
    end
  endtask

  task automatic test_reset_mid();
    int mism;
    start_burst(1024, 5139, 15557);
    capture(100, 1'b0, 0, 1000);
    i_rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_sample !== 12'sd0 || o_last !== 1'b0) begin
      bad++; $display("FAIL rst_mid: got valid=%b busy=%b sample=%0d last=%b want 0 0 0 0",
                      o_valid, o_busy, o_sample, o_last);
    end
    step();
    i_rst = 1'b0;
    step();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_idle: got busy=%b want 0", o_busy); end
    start_burst(1024, 5139, 15557);
    capture(256, 1'b0, 0, 1000);
    mism = 0;
    for (int n = 0; n < 256; n++) if (samp[n] != ref_s[n]) mism++;
    total++; if (samp[0] != 0 || samp[1] != 321) begin
      bad++; $display("FAIL rst_restart: got %0d,%0d want 0,321", samp[0], samp[1]);
    end
    total++; if (n_got != 256 || mism != 0) begin
      bad++; $display("FAIL rst_clean: got len=%0d differing=%0d want 256 0", n_got, mism);
    end
  endtask

  task automatic test_ignored();
    int mism;
    start_burst(1024, 5139, 15557);
    capture(50, 1'b0, 0, 1000);
    i_ready = 1'b0;
    i_start = 1'b1;
    i_amp = 12'sd100;
    step();
    i_start = 1'b0;
    total++; if (o_valid !== 1'b1 || int'(o_sample) != ref_s[50]) begin
      bad++; $display("FAIL start_in_run: got valid=%b sample=%0d want 1 %0d", o_valid, o_sample, ref_s[50]);
    end
    capture(206, 1'b0, 0, 1000);
    mism = 0;
    for (int n = 0; n < 206; n++) if (samp[n] != ref_s[50 + n]) mism++;
    total++; if (n_got != 206 || mism != 0 || last_idx != 205) begin
      bad++; $display("FAIL start_in_run_tail: got len=%0d differing=%0d last=%0d want 206 0 205",
                      n_got, mism, last_idx);
    end
    i_sin = 16'sd5139; i_cos = 16'sd15557; i_coef_valid = 1'b1;
    step();
    i_coef_valid = 1'b0;
    step();
    total++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL coef_in_idle: got busy=%b valid=%b want 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_back_to_back();
    int mism;
`ifdef GOERTZEL_TG_REPEAT_EN
    start_burst(1024, 5139, 15557);
    capture(512, 1'b0, 256, 2000);
    mism = 0;
    for (int n = 0; n < 256; n++) if (samp[256 + n] != ref_s[n]) mism++;
    total++; if (n_got != 512 || samp[256] != 0 || samp[257] != 321) begin
      bad++; $display("FAIL repeat_seed: got len=%0d s256=%0d s257=%0d want 512 0 321",
                      n_got, samp[256], samp[257]);
    end
    total++; if (gaps != 0 || nlast != 2 || mism != 0) begin
      bad++; $display("FAIL repeat_flow: got gaps=%0d lasts=%0d differing=%0d want 0 2 0",
                      gaps, nlast, mism);
    end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL repeat_end: got busy=%b want 0", o_busy); end
`else
    start_burst(1024, 5139, 15557);
    capture(256, 1'b0, 256, 1000);
    mism = 0;
    for (int n = 0; n < 256; n++) if (samp[n] != ref_s[n]) mism++;
    total++; if (n_got != 256 || mism != 0) begin
      bad++; $display("FAIL norepeat_burst: got len=%0d differing=%0d want 256 0", n_got, mism);
    end
    total++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL norepeat_end: got busy=%b valid=%b want 0 0", o_busy, o_valid);
    end
    step();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL norepeat_idle: got busy=%b want 0", o_busy); end
`endif
  endtask

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_amp = 12'sd0;
    i_sin = 16'sd0;
    i_cos = 16'sd0;
    i_coef_valid = 1'b0;
    i_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_tone();
    test_saturation();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
